phase_acc: RTL and testbench

Note-driven phase accumulator (NCO core) for the synth voice path. Accepts a note number and issues it as the address to the phase-increment lookup ROM. It captures the returned 32-bit increment after the ROM's one-cycle registered latency. On every sample tick it advances a wrapping phase accumulator by that increment. The output phase feeds the downstream waveform generators; `wrap_o` provides oscillator sync.

---
 rtl/phase_acc_if.sv | 28 ++
 rtl/phase_acc.sv | 108 ++++++++++
 tb/tb_phase_acc.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/phase_acc_if.sv
// Note-on / sample-tick / ROM / phase bundle between the voice controller and phase_acc.
// master drives note requests, ticks and ROM data; slave is the accumulator.
interface phase_acc_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              note_valid_i;
    logic [ADDR_W-1:0] note_i;
    logic              note_ready_o;
    logic              note_off_i;
    logic              sample_tick_i;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [DATA_W-1:0] rom_data_i;
    logic [DATA_W-1:0] phase_o;
    logic              phase_valid_o;
    logic              wrap_o;
    logic              active_o;

    modport master (
        output note_valid_i, note_i, note_off_i, sample_tick_i, rom_data_i,
        input  note_ready_o, rom_addr_o, phase_o, phase_valid_o, wrap_o, active_o
    );

    modport slave (
        input  note_valid_i, note_i, note_off_i, sample_tick_i, rom_data_i,
        output note_ready_o, rom_addr_o, phase_o, phase_valid_o, wrap_o, active_o
    );
endinterface

// File: rtl/phase_acc.sv
// Note-driven NCO: note -> ROM increment (2 edges) -> wrapping phase accumulator per sample tick.
// Note-ons stall (note_ready_o low) during FETCH/WAIT; optional portamento via PHASE_ACC_GLIDE_EN.
module phase_acc #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 32,
    parameter int GLIDE_SHIFT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    phase_acc_if.slave  bus
);

`ifdef PHASE_ACC_GLIDE_EN
    localparam bit GLIDE_EN = 1'b1;
`else
    localparam bit GLIDE_EN = 1'b0;
`endif

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RUN   = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_inc_cur;
    logic [DATA_W-1:0] r_inc_tgt;
    logic              r_running;
    logic              r_phase_valid;
    logic              r_wrap;

    logic              w_ready;
    logic              w_accept;
    logic              w_acc_en;
    logic [DATA_W:0]   w_sum;
    logic signed [DATA_W:0] w_diff;
    logic signed [DATA_W:0] w_step;

    assign w_ready  = (r_state == IDLE) || (r_state == RUN);
    assign w_accept = bus.note_valid_i && w_ready;
    // running is only ever set outside IDLE, so it alone gates accumulation
    assign w_acc_en = bus.sample_tick_i && r_running;
    assign w_sum    = {1'b0, r_acc} + {1'b0, r_inc_cur};
    assign w_diff   = $signed({1'b0, r_inc_tgt}) - $signed({1'b0, r_inc_cur});
    assign w_step   = w_diff >>> GLIDE_SHIFT;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_rom_addr    <= '0;
            r_acc         <= '0;
            r_inc_cur     <= '0;
            r_inc_tgt     <= '0;
            r_running     <= 1'b0;
            r_phase_valid <= 1'b0;
            r_wrap        <= 1'b0;
        end else begin
            r_phase_valid <= w_acc_en;
            r_wrap        <= w_acc_en && w_sum[DATA_W];
            if (w_acc_en) begin
                r_acc <= w_sum[DATA_W-1:0];
            end
            // glide steps toward the target; the add above already used the old inc_cur
            if (GLIDE_EN && w_acc_en) begin
                if (w_step == '0) begin
                    r_inc_cur <= r_inc_tgt;
                end else begin
                    r_inc_cur <= r_inc_cur + w_step[DATA_W-1:0];
                end
            end

            if (w_accept) begin
                r_rom_addr <= bus.note_i;
                r_state    <= FETCH;
                if (r_state == IDLE) begin
                    r_acc     <= '0;
                    r_running <= 1'b0;
                end
            end else if (bus.note_off_i && (r_state != IDLE)) begin
                r_state   <= IDLE;
                r_running <= 1'b0;
            end else begin
                case (r_state)
                    FETCH: r_state <= WAIT;
                    WAIT: begin
                        r_state   <= RUN;
                        r_inc_tgt <= bus.rom_data_i;
                        // a fresh voice always snaps; a legato load snaps only without glide
                        if (!r_running || !GLIDE_EN) begin
                            r_inc_cur <= bus.rom_data_i;
                        end
                        r_running <= 1'b1;
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign bus.note_ready_o  = w_ready;
    assign bus.rom_addr_o    = r_rom_addr;
    assign bus.phase_o       = r_acc;
    assign bus.phase_valid_o = r_phase_valid;
    assign bus.wrap_o        = r_wrap;
    assign bus.active_o      = (r_state != IDLE);

endmodule

// File: tb/tb_phase_acc.sv
// Directed bench for phase_acc with a registered ROM model, entry[n] = n * 0x0100_0000.
module tb_phase_acc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] rom_q = '0;

    phase_acc_if u_if ();

    phase_acc u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (u_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rom_q <= '0;
        else        rom_q <= {1'b0, u_if.rom_addr_o, 24'h0};
    end
    assign u_if.rom_data_i = rom_q;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic note_on(input logic [6:0] n);
        u_if.note_valid_i = 1'b1;
        u_if.note_i       = n;
        step(1);
        u_if.note_valid_i = 1'b0;
    endtask

    task automatic note_off();
        u_if.note_off_i = 1'b1;
        step(1);
        u_if.note_off_i = 1'b0;
    endtask

    task automatic tick();
        u_if.sample_tick_i = 1'b1;
        step(1);
        u_if.sample_tick_i = 1'b0;
    endtask

    task automatic test_reset();
        step(2);
        checks++; if (u_if.phase_o !== 32'h0) begin errors++; $display("FAIL reset_phase got %h want 0", u_if.phase_o); end
        checks++; if (u_if.phase_valid_o !== 1'b0 || u_if.wrap_o !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b want 00", u_if.phase_valid_o, u_if.wrap_o); end
        checks++; if (u_if.active_o !== 1'b0 || u_if.rom_addr_o !== 7'd0) begin errors++; $display("FAIL reset_active_addr got %b %0d want 0 0", u_if.active_o, u_if.rom_addr_o); end
        rst_n = 1'b1;
        step(1);
        checks++; if (u_if.note_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", u_if.note_ready_o); end
    endtask

    task automatic test_single_note();
        logic [31:0] exp;
        exp = '0;
        note_on(7'd64);
        checks++; if (u_if.rom_addr_o !== 7'd64 || u_if.note_ready_o !== 1'b0) begin errors++; $display("FAIL single_accept got addr %0d rdy %b want 64 0", u_if.rom_addr_o, u_if.note_ready_o); end
        step(2);
        checks++; if (u_if.active_o !== 1'b1 || u_if.note_ready_o !== 1'b1 || u_if.phase_o !== 32'h0) begin errors++; $display("FAIL single_run got act %b rdy %b ph %h want 1 1 0", u_if.active_o, u_if.note_ready_o, u_if.phase_o); end
        for (int k = 0; k < 4; k++) begin
            exp = exp + 32'h4000_0000;
            tick();
            checks++; if (u_if.phase_o !== exp || u_if.phase_valid_o !== 1'b1 || u_if.wrap_o !== (k == 3)) begin errors++; $display("FAIL single_tick%0d got %h v%b w%b want %h v1 w%b", k, u_if.phase_o, u_if.phase_valid_o, u_if.wrap_o, exp, (k == 3)); end
            step(3);
        end
        checks++; if (u_if.phase_valid_o !== 1'b0 || u_if.wrap_o !== 1'b0) begin errors++; $display("FAIL single_pulse_width got v%b w%b want 00", u_if.phase_valid_o, u_if.wrap_o); end
        note_off();
    endtask

    task automatic test_backpressure();
        logic [2:0] rdy;
        u_if.note_valid_i = 1'b1;
        u_if.note_i       = 7'd5;
        rdy[0] = u_if.note_ready_o;
        step(1);
        u_if.note_i = 7'd9;
        rdy[1] = u_if.note_ready_o;
        step(1);
        rdy[2] = u_if.note_ready_o;
        step(1);
        u_if.note_valid_i = 1'b0;
        checks++; if (rdy !== 3'b001) begin errors++; $display("FAIL bp_ready_seq got %b want 001", rdy); end
        checks++; if (u_if.rom_addr_o !== 7'd5 || u_if.note_ready_o !== 1'b1) begin errors++; $display("FAIL bp_one_accept got addr %0d rdy %b want 5 1", u_if.rom_addr_o, u_if.note_ready_o); end
        note_on(7'd9);
        checks++; if (u_if.rom_addr_o !== 7'd9 || u_if.note_ready_o !== 1'b0) begin errors++; $display("FAIL bp_run_accept got addr %0d rdy %b want 9 0", u_if.rom_addr_o, u_if.note_ready_o); end
        step(2);
        note_off();
    endtask

    task automatic test_note_off();
        note_on(7'd1);
        step(2);
        tick();
        step(1);
        tick();
        checks++; if (u_if.phase_o !== 32'h0200_0000) begin errors++; $display("FAIL off_prephase got %h want 02000000", u_if.phase_o); end
        note_off();
        checks++; if (u_if.active_o !== 1'b0 || u_if.note_ready_o !== 1'b1 || u_if.phase_o !== 32'h0200_0000) begin errors++; $display("FAIL off_idle got act %b rdy %b ph %h want 0 1 02000000", u_if.active_o, u_if.note_ready_o, u_if.phase_o); end
        tick();
        checks++; if (u_if.phase_valid_o !== 1'b0 || u_if.phase_o !== 32'h0200_0000) begin errors++; $display("FAIL off_tick_ignored got v%b ph %h want v0 02000000", u_if.phase_valid_o, u_if.phase_o); end
    endtask

    task automatic test_legato();
        note_on(7'd16);
        checks++; if (u_if.phase_o !== 32'h0) begin errors++; $display("FAIL legato_clear got %h want 0", u_if.phase_o); end
        step(2);
        tick();
        tick();
        checks++; if (u_if.phase_o !== 32'h2000_0000) begin errors++; $display("FAIL legato_p got %h want 20000000", u_if.phase_o); end
        note_on(7'd32);
        checks++; if (u_if.rom_addr_o !== 7'd32 || u_if.active_o !== 1'b1) begin errors++; $display("FAIL legato_accept got addr %0d act %b want 32 1", u_if.rom_addr_o, u_if.active_o); end
        step(1);
        tick();
        checks++; if (u_if.phase_o !== 32'h3000_0000 || u_if.phase_valid_o !== 1'b1) begin errors++; $display("FAIL legato_wait_tick got %h v%b want 30000000 v1", u_if.phase_o, u_if.phase_valid_o); end
        tick();
`ifdef PHASE_ACC_GLIDE_EN
        checks++; if (u_if.phase_o !== 32'h4000_0000) begin errors++; $display("FAIL legato_next got %h want 40000000", u_if.phase_o); end
`else
        checks++; if (u_if.phase_o !== 32'h5000_0000) begin errors++; $display("FAIL legato_next got %h want 50000000", u_if.phase_o); end
`endif
        note_off();
    endtask

    task automatic test_abort_and_simultaneous();
        note_on(7'd3);
        note_off();
        checks++; if (u_if.active_o !== 1'b0 || u_if.note_ready_o !== 1'b1) begin errors++; $display("FAIL abort_idle got act %b rdy %b want 0 1", u_if.active_o, u_if.note_ready_o); end
        step(2);
        tick();
        checks++; if (u_if.phase_valid_o !== 1'b0 || u_if.phase_o !== 32'h0) begin errors++; $display("FAIL abort_noload got v%b ph %h want v0 0", u_if.phase_valid_o, u_if.phase_o); end
        note_on(7'd2);
        step(2);
        u_if.note_off_i = 1'b1;
        note_on(7'd4);
        u_if.note_off_i = 1'b0;
        checks++; if (u_if.active_o !== 1'b1 || u_if.rom_addr_o !== 7'd4 || u_if.note_ready_o !== 1'b0) begin errors++; $display("FAIL simul_on_wins got act %b addr %0d rdy %b want 1 4 0", u_if.active_o, u_if.rom_addr_o, u_if.note_ready_o); end
        step(2);
        tick();
        checks++; if (u_if.phase_o !== 32'h0400_0000) begin errors++; $display("FAIL simul_inc got %h want 04000000", u_if.phase_o); end
        note_on(7'd7);
        u_if.sample_tick_i = 1'b1;
        step(1);
        u_if.sample_tick_i = 1'b0;
        checks++; if (u_if.phase_valid_o !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b want 1", u_if.phase_valid_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (u_if.phase_o !== 32'h0 || u_if.phase_valid_o !== 1'b0 || u_if.wrap_o !== 1'b0 || u_if.active_o !== 1'b0 || u_if.rom_addr_o !== 7'd0) begin errors++; $display("FAIL rst_in_wait got ph %h v%b w%b act %b addr %0d want all 0", u_if.phase_o, u_if.phase_valid_o, u_if.wrap_o, u_if.active_o, u_if.rom_addr_o); end
        step(1);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [3];
        exp[0] = 32'h7F00_0000;
        exp[1] = 32'hFE00_0000;
        exp[2] = 32'h7D00_0000;
        note_on(7'd127);
        step(2);
        u_if.sample_tick_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            checks++; if (u_if.phase_o !== exp[k] || u_if.phase_valid_o !== 1'b1 || u_if.wrap_o !== (k == 2)) begin errors++; $display("FAIL b2b_tick%0d got %h v%b w%b want %h v1 w%b", k, u_if.phase_o, u_if.phase_valid_o, u_if.wrap_o, exp[k], (k == 2)); end
        end
        u_if.sample_tick_i = 1'b0;
        step(1);
        checks++; if (u_if.phase_valid_o !== 1'b0 || u_if.phase_o !== 32'h7D00_0000) begin errors++; $display("FAIL b2b_stop got v%b ph %h want v0 7d000000", u_if.phase_valid_o, u_if.phase_o); end
        note_off();
    endtask

`ifdef PHASE_ACC_GLIDE_EN
    task automatic test_glide();
        logic [31:0] p0;
        logic [31:0] p1;
        note_on(7'd16);
        step(2);
        note_on(7'd32);
        step(2);
        p0 = u_if.phase_o;
        tick();
        checks++; if (u_if.phase_o - p0 !== 32'h1000_0000) begin errors++; $display("FAIL glide_d1 got %h want 10000000", u_if.phase_o - p0); end
        p0 = u_if.phase_o;
        tick();
        checks++; if (u_if.phase_o - p0 !== 32'h1100_0000) begin errors++; $display("FAIL glide_d2 got %h want 11000000", u_if.phase_o - p0); end
        p0 = u_if.phase_o;
        tick();
        checks++; if (u_if.phase_o - p0 !== 32'h11F0_0000) begin errors++; $display("FAIL glide_d3 got %h want 11f00000", u_if.phase_o - p0); end
        u_if.sample_tick_i = 1'b1;
        step(400);
        p0 = u_if.phase_o;
        step(1);
        p1 = u_if.phase_o;
        u_if.sample_tick_i = 1'b0;
        checks++; if (p1 - p0 !== 32'h2000_0000) begin errors++; $display("FAIL glide_final got %h want 20000000", p1 - p0); end
        note_off();
    endtask
`endif

    initial begin
        u_if.note_valid_i  = 1'b0;
        u_if.note_i        = '0;
        u_if.note_off_i    = 1'b0;
        u_if.sample_tick_i = 1'b0;
        test_reset();
        test_single_note();
        test_backpressure();
        test_note_off();
        test_legato();
        test_abort_and_simultaneous();
        test_back_to_back();
`ifdef PHASE_ACC_GLIDE_EN
        test_glide();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
